// File: rtl/rp_pkg.sv
// rtl/rp_pkg.sv - shared types and port-count limits for the GPR file slice
package rp_pkg;

  localparam int AW_DEF = 5;
  localparam int XW_DEF = 32;

  localparam int NR_MIN = 1;
  localparam int NR_MAX = 4;
  localparam int NW_MIN = 1;
  localparam int NW_MAX = 3;

  typedef logic [AW_DEF-1:0] reg_addr_t;
  typedef logic [XW_DEF-1:0] xlen_t;

endpackage

// File: rtl/rp_gpr_scoreboard.sv
// rtl/rp_gpr_scoreboard.sv - pending-write scoreboard: busy vector and read hazard lookup
module rp_gpr_scoreboard
  import rp_pkg::*;
#(
  parameter int AW = 5,
  parameter int NR = 2,
  parameter int NW = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sb_set,
  input  logic [AW-1:0]          sb_a,
  input  logic [NW-1:0]          e_rd,
  input  logic [NW-1:0][AW-1:0]  a_rd,
  input  logic [NR-1:0]          e_rs,
  input  logic [NR-1:0][AW-1:0]  a_rs,
  input  logic [NR-1:0]          byp_hit,
  output logic [2**AW-1:0]       busy,
  output logic [NR-1:0]          h_rs
);

  localparam int NE = 2**AW;

  // x0 never becomes pending, so only entries 1.. carry state
  logic [NE-1:1] busy_q;
  logic [NE-1:1] busy_d;

  always_comb begin
    logic clr;
    busy_d = busy_q;
    for (int i = 1; i < NE; i++) begin
      clr = 1'b0;
      for (int w = 0; w < NW; w++) begin
        if (e_rd[w] && a_rd[w] == AW'(i)) clr = 1'b1;
      end
      // a new issue to the same register outranks the retiring write
      busy_d[i] = (sb_set && sb_a == AW'(i)) | (busy_q[i] & ~clr);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy = {busy_q, 1'b0};

  always_comb begin
    for (int r = 0; r < NR; r++) begin
      h_rs[r] = e_rs[r] & busy[a_rs[r]] & ~byp_hit[r];
    end
  end

endmodule

// File: rtl/rp_gpr_sb.sv
// rtl/rp_gpr_sb.sv - multi-port integer register file with write bypass and scoreboard
module rp_gpr_sb
  import rp_pkg::*;
#(
  parameter int AW  = 5,
  parameter int XW  = 32,
  parameter int NR  = 2,
  parameter int NW  = 2,
  parameter int BYP = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NR-1:0]          e_rs,
  input  logic [NR-1:0][AW-1:0]  a_rs,
  output logic [NR-1:0][XW-1:0]  d_rs,
  output logic [NR-1:0]          h_rs,
  input  logic [NW-1:0]          e_rd,
  input  logic [NW-1:0][AW-1:0]  a_rd,
  input  logic [NW-1:0][XW-1:0]  d_rd,
  input  logic                   sb_set,
  input  logic [AW-1:0]          sb_a,
  output logic [2**AW-1:0]       busy
);

  localparam int NE = 2**AW;

  if (NR < NR_MIN || NR > NR_MAX) begin : g_bad_nr
    $error("rp_gpr_sb: NR out of range");
  end
  if (NW < NW_MIN || NW > NW_MAX) begin : g_bad_nw
    $error("rp_gpr_sb: NW out of range");
  end

  logic [XW-1:0] regs [1:NE-1];
  logic [NR-1:0] byp_hit;

  // later ports are assigned last, so the highest index wins a collision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NE; i++) regs[i] <= '0;
    end else begin
      for (int w = 0; w < NW; w++) begin
        if (e_rd[w] && a_rd[w] != '0) regs[a_rd[w]] <= d_rd[w];
      end
    end
  end

  // bypass is masked in reset so every read port reports zero
  always_comb begin
    for (int r = 0; r < NR; r++) begin
      d_rs[r]    = '0;
      byp_hit[r] = 1'b0;
      if (a_rs[r] != '0) begin
        d_rs[r] = regs[a_rs[r]];
        if (BYP != 0 && !rst) begin
          for (int w = 0; w < NW; w++) begin
            if (e_rd[w] && a_rd[w] == a_rs[r]) begin
              d_rs[r]    = d_rd[w];
              byp_hit[r] = 1'b1;
            end
          end
        end
      end
    end
  end

  rp_gpr_scoreboard #(
    .AW (AW),
    .NR (NR),
    .NW (NW)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .sb_set  (sb_set),
    .sb_a    (sb_a),
    .e_rd    (e_rd),
    .a_rd    (a_rd),
    .e_rs    (e_rs),
    .a_rs    (a_rs),
    .byp_hit (byp_hit),
    .busy    (busy),
    .h_rs    (h_rs)
  );

endmodule

// File: tb/tb_rp_gpr_sb.sv
// tb/tb_rp_gpr_sb.sv - scoreboard bench for rp_gpr_sb against a register-array reference model
module tb_rp_gpr_sb;

  localparam int AW = 5;
  localparam int XW = 32;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int NE = 2**AW;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NR-1:0]         e_rs = '0;
  logic [NR-1:0][AW-1:0] a_rs = '0;
  logic [NR-1:0][XW-1:0] d_rs;
  logic [NR-1:0]         h_rs;
  logic [NW-1:0]         e_rd = '0;
  logic [NW-1:0][AW-1:0] a_rd = '0;
  logic [NW-1:0][XW-1:0] d_rd = '0;
  logic                  sb_set = 1'b0;
  logic [AW-1:0]         sb_a = '0;
  logic [NE-1:0]         busy;

  rp_gpr_sb #(.AW(AW), .XW(XW), .NR(NR), .NW(NW), .BYP(1)) dut (
    .clk(clk), .rst(rst),
    .e_rs(e_rs), .a_rs(a_rs), .d_rs(d_rs), .h_rs(h_rs),
    .e_rd(e_rd), .a_rd(a_rd), .d_rd(d_rd),
    .sb_set(sb_set), .sb_a(sb_a), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                    id;
    logic [NR-1:0][XW-1:0] d;
    logic [NR-1:0]         dmask;
    logic [NR-1:0]         h;
    logic [NE-1:0]         busy;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int step_id = 0;

  // reference state: architectural registers and pending flags
  logic [XW-1:0] mem [NE];
  logic          mbusy [NE];

  // staged stimulus for the next step
  logic                  s_rst;
  logic [NR-1:0]         s_e_rs;
  logic [NR-1:0][AW-1:0] s_a_rs;
  logic [NW-1:0]         s_e_rd;
  logic [NW-1:0][AW-1:0] s_a_rd;
  logic [NW-1:0][XW-1:0] s_d_rd;
  logic                  s_sb_set;
  logic [AW-1:0]         s_sb_a;

  task automatic clr_stage();
    s_rst = 1'b0; s_e_rs = '0; s_a_rs = '0; s_e_rd = '0;
    s_a_rd = '0; s_d_rd = '0; s_sb_set = 1'b0; s_sb_a = '0;
  endtask

  function automatic int winner(input logic [AW-1:0] a);
    for (int w = NW-1; w >= 0; w--)
      if (s_e_rd[w] && s_a_rd[w] == a) return w;
    return -1;
  endfunction

  task automatic step();
    exp_t x;
    int   w;
    @(posedge clk); #1;
    rst = s_rst; e_rs = s_e_rs; a_rs = s_a_rs; e_rd = s_e_rd;
    a_rd = s_a_rd; d_rd = s_d_rd; sb_set = s_sb_set; sb_a = s_sb_a;
    x.id = step_id++;
    x.dmask = s_rst ? '1 : s_e_rs;
    for (int r = 0; r < NR; r++) begin
      w = winner(s_a_rs[r]);
      if (s_rst || s_a_rs[r] == 0) x.d[r] = '0;
      else if (w >= 0)             x.d[r] = s_d_rd[w];
      else                         x.d[r] = mem[s_a_rs[r]];
      x.h[r] = s_e_rs[r] && !s_rst && s_a_rs[r] != 0 && mbusy[s_a_rs[r]] && w < 0;
    end
    for (int i = 0; i < NE; i++) x.busy[i] = s_rst ? 1'b0 : mbusy[i];
    q.push_back(x);
    if (s_rst) begin
      for (int i = 0; i < NE; i++) begin mem[i] = '0; mbusy[i] = 1'b0; end
    end else begin
      for (int a = 1; a < NE; a++) begin
        w = winner(AW'(a));
        if (w >= 0) begin mem[a] = s_d_rd[w]; mbusy[a] = 1'b0; end
        if (s_sb_set && s_sb_a == AW'(a)) mbusy[a] = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      for (int r = 0; r < NR; r++) begin
        if (x.dmask[r]) begin
          n_cmp++;
          if (d_rs[r] !== x.d[r]) begin
            n_bad++;
            $display("FAIL rd_data step %0d port %0d: got %h want %h", x.id, r, d_rs[r], x.d[r]);
          end
        end
      end
      n_cmp++;
      if (h_rs !== x.h) begin
        n_bad++;
        $display("FAIL hazard step %0d: got %b want %b", x.id, h_rs, x.h);
      end
      n_cmp++;
      if (busy !== x.busy) begin
        n_bad++;
        $display("FAIL busy step %0d: got %h want %h", x.id, busy, x.busy);
      end
    end
  end

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
    return AW'($urandom_range(0, NE-1));
  endfunction

  initial begin
    for (int i = 0; i < NE; i++) begin mem[i] = '0; mbusy[i] = 1'b0; end

    // reset state with junk on the inputs
    clr_stage(); s_rst = 1'b1; s_e_rs = '1; s_a_rs[0] = 5'd3; s_a_rs[1] = 5'd0;
    s_e_rd = 2'b01; s_a_rd[0] = 5'd3; s_d_rd[0] = 32'hFFFF_0000; s_sb_set = 1'b1; s_sb_a = 5'd3;
    step();

    // x5 write then dual read
    clr_stage(); s_e_rd[0] = 1'b1; s_a_rd[0] = 5'd5; s_d_rd[0] = 32'hDEAD_BEEF; step();
    clr_stage(); s_e_rs = 2'b11; s_a_rs[0] = 5'd5; s_a_rs[1] = 5'd5; step();

    // colliding writes to x7 with same-cycle read
    clr_stage(); s_e_rd = 2'b11; s_a_rd[0] = 5'd7; s_a_rd[1] = 5'd7;
    s_d_rd[0] = 32'h11; s_d_rd[1] = 32'h22; s_e_rs = 2'b01; s_a_rs[0] = 5'd7; step();
    clr_stage(); s_e_rs = 2'b11; s_a_rs[0] = 5'd7; s_a_rs[1] = 5'd7; step();

    // x0 writes and sb_set are ignored
    clr_stage(); s_e_rd[1] = 1'b1; s_a_rd[1] = 5'd0; s_d_rd[1] = 32'h1234;
    s_e_rs = 2'b11; s_a_rs[0] = 5'd0; s_a_rs[1] = 5'd0; step();
    clr_stage(); s_e_rs = 2'b11; s_sb_set = 1'b1; s_sb_a = 5'd0; step();
    clr_stage(); s_e_rs = 2'b11; step();

    // pending x9 resolved by a bypassed write
    clr_stage(); s_sb_set = 1'b1; s_sb_a = 5'd9; step();
    clr_stage(); s_e_rs = 2'b01; s_a_rs[0] = 5'd9; step();
    clr_stage(); s_e_rs = 2'b11; s_a_rs[0] = 5'd9; s_a_rs[1] = 5'd9;
    s_e_rd[1] = 1'b1; s_a_rd[1] = 5'd9; s_d_rd[1] = 32'h55; step();
    clr_stage(); s_e_rs = 2'b01; s_a_rs[0] = 5'd9; step();

    // set beats the clearing write on x3
    clr_stage(); s_sb_set = 1'b1; s_sb_a = 5'd3;
    s_e_rd[0] = 1'b1; s_a_rd[0] = 5'd3; s_d_rd[0] = 32'h77; step();
    clr_stage(); s_e_rs = 2'b11; s_a_rs[0] = 5'd3; s_a_rs[1] = 5'd3; step();

    // reset mid-cycle wipes pending x4; later write is ordinary
    clr_stage(); s_sb_set = 1'b1; s_sb_a = 5'd4;
    s_e_rd[0] = 1'b1; s_a_rd[0] = 5'd6; s_d_rd[0] = 32'h66; step();
    clr_stage(); s_rst = 1'b1; s_e_rs = 2'b11; s_a_rs[0] = 5'd4; s_a_rs[1] = 5'd6;
    s_e_rd[1] = 1'b1; s_a_rd[1] = 5'd6; s_d_rd[1] = 32'h99; step();
    clr_stage(); s_e_rd[0] = 1'b1; s_a_rd[0] = 5'd4; s_d_rd[0] = 32'hABCD; s_e_rs = 2'b01; s_a_rs[0] = 5'd4; step();
    clr_stage(); s_e_rs = 2'b11; s_a_rs[0] = 5'd4; s_a_rs[1] = 5'd6; step();

    for (int n = 0; n < 3000; n++) begin
      clr_stage();
      s_rst = ($urandom_range(0, 99) == 0);
      for (int r = 0; r < NR; r++) begin
        s_e_rs[r] = ($urandom_range(0, 3) != 0);
        s_a_rs[r] = rand_addr();
      end
      for (int w = 0; w < NW; w++) begin
        s_e_rd[w] = ($urandom_range(0, 2) == 0);
        s_a_rd[w] = rand_addr();
        s_d_rd[w] = $urandom;
      end
      s_sb_set = ($urandom_range(0, 2) == 0);
      s_sb_a   = rand_addr();
      step();
    end

    clr_stage(); s_rst = 1'b1; step();
    repeat (2) @(posedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rp_gpr_sb.md
RP_GPR_SB -- requirements
Module: rp_gpr_sb

Interface
REQ-001 Parameter AW, default 5, register address width; 4 selects RV32E.
REQ-002 Parameter XW, default 32, register width (XLEN).
REQ-003 Parameter NR, default 2, number of read ports (1..4).
REQ-004 Parameter NW, default 2, number of write ports (1..3).
REQ-005 Parameter BYP, default 1, enables same-cycle write-to-read bypass.
REQ-006 clk  input  1  clock.
REQ-007 rst  input  1  reset; asynchronous, active-high.
REQ-008 e_rs  input  NR  per-port read enable.
REQ-009 a_rs  input  NR x AW  per-port read address.
REQ-010 d_rs  output  NR x XW  per-port read data.
REQ-011 h_rs  output  NR  per-port hazard flag: the read returns stale data.
REQ-012 e_rd  input  NW  per-port write enable.
REQ-013 a_rd  input  NW x AW  per-port write address.
REQ-014 d_rd  input  NW x XW  per-port write data.
REQ-015 sb_set  input  1  marks a register pending; a long-latency op was issued.
REQ-016 sb_a  input  AW  address marked pending by sb_set.
REQ-017 busy  output  2**AW  scoreboard vector, bit 0 constantly 0.

Function
REQ-018 Register x0 SHALL read as 0; writes to x0 and sb_set to x0 SHALL have no effect.
REQ-019 A write with e_rd[w]=1 and a_rd[w]!=0 SHALL update the register on the next rising clk.
REQ-020 If several write ports target one address in a cycle, the highest port index SHALL win.
REQ-021 A write with e_rd[w]=1 SHALL clear busy[a_rd[w]] on the same edge.
REQ-022 sb_set=1 SHALL set busy[sb_a] on the next edge.
REQ-023 If sb_set and a write target the same address in one cycle, set SHALL win: busy=1, data updated.
REQ-024 Reads SHALL be combinational, with zero-cycle latency from a_rs to d_rs.
REQ-025 BYP=1: if a_rs[r] matches an enabled write this cycle, d_rs[r] SHALL return the winning d_rd (highest index).
REQ-026 BYP=0: d_rs[r] SHALL return the stored register contents only.
REQ-027 h_rs[r] SHALL equal e_rs[r] & busy[a_rs[r]] & ~(BYP & write to a_rs[r] this cycle).
REQ-028 When e_rs[r]=0, h_rs[r] SHALL be 0; d_rs[r] is don't-care.
REQ-029 a_rs[r]=0 SHALL give d_rs[r]=0 and h_rs[r]=0 regardless of writes or bypass.
REQ-030 Read ports SHALL be fully independent; identical addresses on all ports are legal.

Reset
REQ-031 rst=1 SHALL clear all registers and all busy bits immediately, without waiting for clk.
REQ-032 While rst=1: d_rs=0, h_rs=0, busy=0; writes and sb_set ignored.
REQ-033 A pending op in flight at reset SHALL be forgotten; its later write is an ordinary write.
REQ-034 Reset deassertion SHALL be synchronised externally; the block adds no synchroniser.

Structure
REQ-035 Shared package rp_pkg SHALL hold the register address type, XLEN type and the NR/NW limit constants.
REQ-036 Scoreboard SHALL be a sub-module rp_gpr_scoreboard (busy vector, set/clear priority, hazard lookup).
REQ-037 Storage SHALL be flops for entries 1..2**AW-1; entry 0 SHALL NOT be implemented.
REQ-038 Out-of-range NR/NW SHALL fail elaboration with an assertion.

Verification
REQ-039 Write 0xDEADBEEF to x5 via port 0, read next cycle on ports 0 and 1 -> both 0xDEADBEEF, h_rs=0.
REQ-040 Same cycle: port 0 writes 0x11 to x7, port 1 writes 0x22 to x7 -> x7=0x22; BYP=1 same-cycle read of x7 -> 0x22.
REQ-041 Write 0x1234 to x0, then read x0 -> 0, busy[0]=0; sb_set on x0 -> busy unchanged.
REQ-042 sb_set x9; next cycle read x9 -> h_rs=1; write 0x55 to x9 -> BYP=1 same-cycle h_rs=0 and d_rs=0x55, busy[9]=0 next.
REQ-043 Same cycle: sb_set x3 and write 0x77 to x3 -> x3=0x77, busy[3]=1.
REQ-044 sb_set x4, then assert rst mid-cycle -> busy and registers 0 before the next edge; later write to x4 stores normally.
